// File: rtl/bp_pkg.sv
// Shared types for the branch target buffer:
// FSM states, counter encodings, sequential-PC helper.
package bp_pkg;

  typedef enum logic {
    INIT,
    RUN
  } bp_state_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [31:0] seq_pc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Two-bit saturating direction counter,
// next-state only.
import bp_pkg::*;

module sat_ctr2 (
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (1'b1)
      (taken_i && ctr_i != ST):
        ctr_o = ctr_i + 2'd1;
      (!taken_i && ctr_i != SNT):
        ctr_o = ctr_i - 2'd1;
      default:
        ctr_o = ctr_i;
    endcase
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Direct-mapped BTB with 2-bit direction counters,
// trained from EX, swept clear after reset/flush.
import bp_pkg::*;

module branch_predictor_ctrl #(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_if_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  output logic        pred_hit_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_mispredict_i,
  input  logic        flush_req_i,
  output logic        busy_o,
  output logic [31:0] perf_mispredict_o
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(ENTRIES - 1);

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  entry_t           tbl_q [ENTRIES];
  logic [31:0]      perf_q;

  logic             run;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  entry_t           lk_e;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  entry_t           up_e;
  logic             up_hit;
  logic             up_ok;
  logic [1:0]       ctr_nxt;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  entry_t           wr_e;

  logic             unused_pc_bits;

  assign unused_pc_bits =
    ^{pc_if_i[1:0], upd_pc_i[1:0]};

  assign run = (state_q == RUN);

  assign lk_idx = pc_if_i[IDX_W+1:2];
  assign lk_tag = pc_if_i[31:IDX_W+2];
  assign lk_e   = tbl_q[lk_idx];
  assign lk_hit = run & lk_e.valid
                & (lk_e.tag == lk_tag);

  assign pred_hit_o    = lk_hit;
  assign pred_taken_o  = lk_hit & lk_e.ctr[1];
  assign pred_target_o = pred_taken_o
                       ? lk_e.target
                       : seq_pc(pc_if_i);

  assign busy_o            = ~run;
  assign perf_mispredict_o = perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      INIT: begin
        if (flush_req_i) begin
          init_idx_d = '0;
        end else if (init_idx_q == LAST) begin
          state_d = RUN;
        end else begin
          init_idx_d = init_idx_q + 1'b1;
        end
      end
      RUN: begin
        if (flush_req_i) begin
          state_d    = INIT;
          init_idx_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[31:IDX_W+2];
  assign up_e   = tbl_q[up_idx];
  assign up_hit = up_e.valid
                & (up_e.tag == up_tag);
  assign up_ok  = run & upd_valid_i
                & ~flush_req_i;

  sat_ctr2 u_ctr (
    .ctr_i   (up_e.ctr),
    .taken_i (upd_taken_i),
    .ctr_o   (ctr_nxt)
  );

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = up_idx;
    wr_e   = up_e;
    unique case (1'b1)
      !run: begin
        wr_en  = 1'b1;
        wr_idx = init_idx_q;
        wr_e   = '{valid:  1'b0,
                   tag:    '0,
                   target: '0,
                   ctr:    WNT};
      end
      (up_ok && up_hit): begin
        wr_en    = 1'b1;
        wr_e.ctr = ctr_nxt;
        if (upd_taken_i) begin
          wr_e.target = upd_target_i;
        end
      end
      (up_ok && !up_hit && upd_taken_i): begin
        wr_en = 1'b1;
        wr_e  = '{valid:  1'b1,
                  tag:    up_tag,
                  target: upd_target_i,
                  ctr:    WT};
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Contents are don't-care until the sweep
  // has rewritten every entry.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tbl_q[wr_idx] <= wr_e;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (upd_valid_i && upd_mispredict_i
                 && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

endmodule

// File: doc/branch_predictor_ctrl.md
# branch_predictor_ctrl

Direct-mapped branch target buffer with 2-bit saturating direction counters that supplies the IF stage with a predicted next PC and is trained by resolved branches/jumps from EX. It sits beside the hazard unit: IF consumes its prediction, EX reports the actual outcome, and the hazard unit's PC-compare logic catches wrong predictions. An internal init sequencer clears the table after reset or on a flush request.

## Interface
- ENTRIES, 16: table depth; power of two, 4..256.
- IDX_W, $clog2(ENTRIES): index width (derived, not overridden).
- TAG_W, 30-IDX_W: tag width (derived).

- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- pc_if_i  in  32  fetch PC to predict.
- pred_taken_o  out  1  predict redirect.
- pred_target_o  out  32  predicted next PC.
- pred_hit_o  out  1  valid tag match (independent of direction).
- upd_valid_i  in  1  EX reports a resolved control-transfer this cycle.
- upd_pc_i  in  32  PC of that instruction.
- upd_taken_i  in  1  actual direction.
- upd_target_i  in  32  actual target (ALU result).
- upd_mispredict_i  in  1  hazard unit flagged a redirect for this instruction.
- flush_req_i  in  1  one-cycle pulse: invalidate whole table.
- busy_o  out  1  init sweep in progress.
- perf_mispredict_o  out  32  saturating mispredict count.

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry = {valid, tag, target[31:0], ctr[1:0]}; ctr encoding SNT=00, WNT=01, WT=10, ST=11.
- FSM states INIT, RUN.
  - INIT: init_idx counts 0..ENTRIES-1, one entry per cycle: valid<=0, ctr<=WNT. At init_idx==ENTRIES-1 go RUN next cycle. busy_o=1.
  - RUN: busy_o=0. flush_req_i -> INIT, init_idx<=0.
- Lookup (RUN only, combinational): hit = valid & tag match; pred_taken_o = hit & ctr[1]; pred_target_o = pred_taken_o ? target : pc_if_i+4 (32-bit wrap). In INIT: pred_taken_o=0, pred_hit_o=0, target=pc_if_i+4.
- Update (RUN, upd_valid_i=1):
  - hit: ctr saturating +1 if taken, -1 if not; if taken, target<=upd_target_i.
  - miss & taken: allocate/replace: valid=1, tag, target, ctr=WT.
  - miss & not taken: no write.
- Update while INIT or on flush_req_i cycle: ignored (table write suppressed).
- perf_mispredict_o increments when upd_valid_i & upd_mispredict_i, saturates at 0xFFFF_FFFF; not cleared by flush, cleared only by reset.

## Timing
- Reset (async assert): state=INIT, init_idx=0, busy_o=1, pred_taken_o=0, pred_hit_o=0, pred_target_o=pc_if_i+4, perf_mispredict_o=0. Table contents undefined until sweep completes.
- After rst_ni deasserts, busy_o high exactly ENTRIES cycles, low on cycle ENTRIES+1.
- Lookup latency 0 cycles from pc_if_i, reading registered state.
- Update visible to lookup the cycle after upd_valid_i; same-cycle lookup/update to same index sees old entry (no bypass).
- flush_req_i during INIT restarts sweep at index 0.
- Reset asserted mid-sweep or mid-update: immediate return to INIT, pending update lost.

## Structure
- Package bp_pkg: bp_state_e {INIT, RUN}; ctr constants SNT/WNT/WT/ST; entry struct typedef parameterized by tag width via localparams in module.
- Sub-module sat_ctr2: combinational 2-bit saturating next-state (ctr_i, taken_i -> ctr_o); instantiated once for the update path.
- Table held as flop arrays (small depth); no SRAM macro.

## Test plan
- Reset release, ENTRIES=16 -> busy_o=1 for 16 cycles; pc_if_i=0x100 during sweep gives pred_taken_o=0, target 0x104.
- Update pc=0x200 taken target 0x340 -> next cycle pc_if_i=0x200 gives hit=1, taken=1, target 0x340.
- Two not-taken updates at 0x200 (WT->WNT->SNT) -> taken=0, hit=1, target 0x204; one more not-taken keeps SNT; three taken -> ST, further taken stays ST.
- Alias pc=0x240 (same index, different tag) taken to 0x500 -> 0x200 now misses, 0x240 predicts 0x500.
- flush_req_i pulse in RUN with concurrent update -> update dropped, 16-cycle sweep, all lookups miss afterwards.
- 3 updates with upd_mispredict_i=1 -> perf_mispredict_o=3; preload near saturation (force) -> holds 0xFFFF_FFFF; rst_ni low mid-sweep -> busy_o stays 1 and sweep restarts at 0.
